// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8:1 MUX scan sequencer.
package mux_scan_pkg;
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam int SEL_W = 3;
    localparam int NUM_CH = 8;
    localparam logic [SEL_W-1:0] LAST_SEL = 3'd7;
endpackage

// File: rtl/mux_scan_if.sv
// Bundle between the scan sequencer (slave) and its requester plus MUX stage (master).
interface mux_scan_if #(parameter int CNT_W = 4);
    import mux_scan_pkg::*;

    // start is a request level sampled only while idle (no queuing); done is a one-cycle
    // completion strobe, and data/valid hold their value until the next completion.
    logic              start;
    logic              mux_y;
    logic [SEL_W-1:0]  mux_s;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] data;
    logic              valid;
    state_t            state;
    logic [CNT_W-1:0]  settle_cnt;

    modport master (
        output start, mux_y,
        input  mux_s, busy, done, data, valid, state, settle_cnt
    );

    modport slave (
        input  start, mux_y,
        output mux_s, busy, done, data, valid, state, settle_cnt
    );
endinterface

// File: rtl/mux_scan_sequencer_settle.sv
// Loadable down-counter timing the settle interval after each select change.
module mux_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - CNT_W'(1);
        end
    end

    assign zero = (value == '0);
endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the MUX select through all 8 codes and assembles the sampled word in input-bit order.
// Define MUX_SCAN_CONTINUOUS_EN to rescan forever after the first accepted start.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic      clk,
    input  logic      rst,
    mux_scan_if.slave bus
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..15");
    end
    if ((SETTLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for SETTLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] shift_q;
    logic [NUM_CH-1:0] shift_next;
    logic [NUM_CH-1:0] data_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic              t_load;
    logic              t_dec;
    logic              t_zero;
    logic [CNT_W-1:0]  t_value;

    mux_settle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (RELOAD),
        .dec      (t_dec),
        .value    (t_value),
        .zero     (t_zero)
    );

    // Select k routes MUX input 7-k, so the sample lands in bit 7-k to undo the reversal.
    always_comb begin
        shift_next = shift_q;
        shift_next[LAST_SEL - sel] = bus.mux_y;
    end

    always_comb begin
        t_load = 1'b0;
        t_dec  = 1'b0;
        case (state)
            IDLE: t_load = bus.start;
            SCAN: begin
                t_dec = !t_zero;
`ifdef MUX_SCAN_CONTINUOUS_EN
                t_load = t_zero;
`else
                t_load = t_zero && (sel != LAST_SEL);
`endif
            end
            default: t_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            shift_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SCAN;
                        sel    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (t_zero) begin
                        shift_q <= shift_next;
                        if (sel != LAST_SEL) begin
                            sel <= sel + 1'b1;
                        end else begin
                            data_q  <= shift_next;
                            valid_q <= 1'b1;
                            done_q  <= 1'b1;
                            sel     <= '0;
`ifdef MUX_SCAN_CONTINUOUS_EN
                            state   <= SCAN;
`else
                            state   <= IDLE;
                            busy_q  <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mux_s      = sel;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.state      = state;
    assign bus.settle_cnt = t_value;
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream sequencer for the 8:1 channel MUX.
- Steps the MUX select through all 8 codes, waits a settle interval per code, samples the MUX output and assembles one 8-bit word.
- Uses a start/done handshake.
- Undoes the MUX's reversed select mapping, where select k routes input bit 7-k. The captured word is therefore bit-for-bit equal to the MUX input vector.

Parameters:
- SETTLE_CYCLES, default 1: cycles between a select change and the sample edge. Legal range 1..15. Values outside this range are a configuration error.
- CNT_W, default 4: width of the settle counter. Must hold SETTLE_CYCLES.

Ports:
- clk  in  1  Single clock. All state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- start  in  1  Request one scan. Sampled only in IDLE.
- mux_y  in  1  MUX output, fed back from the MUX stage.
- mux_s  out  3  Select driven to the MUX stage.
- busy  out  1  High while a scan is in progress.
- done  out  1  Single-cycle pulse when a word completes.
- data  out  8  Last completed word. Bit n equals MUX input bit n.
- valid  out  1  High once at least one scan has completed since reset.

Behaviour:
- Reset (async, rst=1): state IDLE, mux_s=0, busy=0, done=0, data=0, valid=0, settle counter=0, internal shift register=0.
- States:
  - IDLE: mux_s held at 0, busy=0.
    - If start=1 at edge E0: load counter with SETTLE_CYCLES-1, keep mux_s=0, busy=1, go to SCAN.
  - SCAN, at each edge:
    - If counter≠0: decrement.
    - If counter=0 (the sample edge): capture mux_y into internal bit 7-mux_s.
      - If mux_s<7: mux_s<=mux_s+1 and reload the counter.
      - If mux_s=7 (last channel): copy the assembled word, including this edge's sample, to data; set valid=1; pulse done for one cycle. Then:
        - Without the optional feature: mux_s<=0, busy=0, go to IDLE.
        - With the optional feature: restart the scan (see Optional Feature).
- Timing: select k is applied at edge E0+k*SETTLE_CYCLES and sampled at edge E0+(k+1)*SETTLE_CYCLES. done is high during the cycle following edge E0+8*SETTLE_CYCLES.
- Latency from start to done: 8*SETTLE_CYCLES cycles.
- data changes only on completion edges. It is stable between scans and during a scan.
- start while busy=1: ignored; no queuing.
- start asserted in the same cycle done is high: accepted. IDLE is already entered on that edge, so the next scan begins on the following edge.
- start held high continuously: back-to-back scans with one IDLE cycle between them.
- rst mid-scan: abort immediately to the reset values. The partial word is discarded and data/valid are cleared.
- mux_s wraps only through an explicit reload to 0, never by 3-bit overflow.

Optional Feature:
- Macro: MUX_SCAN_CONTINUOUS_EN.
- Defined: after the first accepted start, the block never returns to IDLE.
  - On each completion edge: mux_s<=0, counter reloads, busy stays 1.
  - done pulses every 8*SETTLE_CYCLES cycles.
  - start is ignored after the first scan begins.
  - rst is the only way to stop scanning.
- Undefined: single-shot behaviour as above.

Decomposition:
- Package mux_scan_pkg holds:
  - state enum (IDLE, SCAN)
  - SEL_W=3
  - NUM_CH=8
  - LAST_SEL=3'd7
- One sub-module is natural: mux_settle_timer.
  - Loadable down-counter with load, value and zero-flag outputs.
  - Parameterised by CNT_W, with the same clk/rst.
- The FSM, select register and shift/capture register stay in the top.

Test Plan:
- Bit-ordering check. Setup: SETTLE_CYCLES=1, bench MUX model with i=8'hA5, start pulsed once. Required:
  - mux_s = 0,1,…,7 on consecutive cycles;
  - done exactly 8 cycles after the start edge;
  - data=8'hA5, valid=1, busy=0 afterwards.
- Single-bit corners. Setup: SETTLE_CYCLES=1. Required: i=8'h01 gives data=8'h01, and i=8'h80 gives data=8'h80.
- Settle interval. Setup: SETTLE_CYCLES=3, i=8'h3C, i changes to 8'hFF only after done. Required:
  - each mux_s value is held 3 cycles;
  - done at 24 cycles;
  - data=8'h3C, with no contamination from the later change.
- Start while busy. Setup: start pulsed again at cycle 4 of a scan. Required: ignored; exactly one done; the next scan occurs only after a fresh start in IDLE.
- Reset mid-scan. Setup: rst asserted asynchronously at cycle 5 of a scan that follows a completed scan with data=8'h5A. Required: mux_s=0, busy=0, done=0, data=0, valid=0 immediately, with no done afterwards.
- Continuous mode. Setup: MUX_SCAN_CONTINUOUS_EN defined, SETTLE_CYCLES=1, one start; i=8'h11 in the first scan, 8'h22 in the second. Required:
  - done pulses 8 cycles apart;
  - data=8'h11, then data=8'h22;
  - busy never drops.
